// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone B4 definitions for the SRAM target slice:
//   - wb_cti_e        : cycle type identifiers (classic, incrementing, end)
//   - wb_bte_e        : burst type extensions (linear, wrap4/8/16)
//   - wb_sram_state_e : responder FSM states
// Optional build macro: WB_SRAM_TARGET_WAIT_EN adds the WAIT state.
// ----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [2:0] {
        WB_CTI_CLASSIC = 3'b000,
        WB_CTI_INCR    = 3'b010,
        WB_CTI_EOB     = 3'b111
    } wb_cti_e;

    typedef enum logic [1:0] {
        WB_BTE_LINEAR,
        WB_BTE_WRAP4,
        WB_BTE_WRAP8,
        WB_BTE_WRAP16
    } wb_bte_e;

`ifdef WB_SRAM_TARGET_WAIT_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIC,
        ST_BURST,
        ST_WAIT
    } wb_sram_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIC,
        ST_BURST
    } wb_sram_state_e;
`endif

endpackage

// File: rtl/wb_if.sv
// ----------------------------------------------------------------------------
// wb_if
// Wishbone B4 bus bundle between one master and one slave.
//   ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE : master -> slave
//   DAT_R, ACK, ERR                          : slave -> master
// CTI is kept as a plain 3-bit vector so undefined codes can reach the slave.
// ----------------------------------------------------------------------------
interface wb_if #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32
);

    logic [WB_ADDR_WIDTH-1:0]   ADR;
    logic [WB_DATA_WIDTH-1:0]   DAT_W;
    logic [WB_DATA_WIDTH/8-1:0] SEL;
    logic                       CYC;
    logic                       STB;
    logic                       WE;
    logic [2:0]                 CTI;
    logic [1:0]                 BTE;
    logic [WB_DATA_WIDTH-1:0]   DAT_R;
    logic                       ACK;
    logic                       ERR;

    modport master (
        output ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
        input  DAT_R, ACK, ERR
    );

    modport slave (
        input  ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
        output DAT_R, ACK, ERR
    );

endinterface

// File: rtl/wb_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// wb_burst_addr_gen
// Combinational next word index for an incrementing Wishbone burst.
//   addr      in  ADDR_BITS  current word index
//   bte       in  2          burst type extension
//   next_addr out ADDR_BITS  index of the following beat
//   overflow  out 1          linear burst would carry out of the array
// Wrapping bursts keep the upper index bits and count the low bits modulo N.
// ----------------------------------------------------------------------------
module wb_burst_addr_gen
    import wb_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [1:0]           bte,
    output logic [ADDR_BITS-1:0] next_addr,
    output logic                 overflow
);

    logic [ADDR_BITS:0]   sum;
    logic [ADDR_BITS-1:0] wrap_mask;

    assign sum = {1'b0, addr} + (ADDR_BITS+1)'(1);

    // The mask marks the index bits that are allowed to count; bits outside
    // it are copied from the current index so wraps stay inside their block.
    always_comb begin
        wrap_mask = '1;
        overflow  = 1'b0;
        case (wb_bte_e'(bte))
            WB_BTE_LINEAR: begin
                wrap_mask = '1;
                overflow  = sum[ADDR_BITS];
            end
            WB_BTE_WRAP4:  wrap_mask = ADDR_BITS'(3);
            WB_BTE_WRAP8:  wrap_mask = ADDR_BITS'(7);
            WB_BTE_WRAP16: wrap_mask = ADDR_BITS'(15);
            default:       wrap_mask = '1;
        endcase
        next_addr = (addr & ~wrap_mask) | (sum[ADDR_BITS-1:0] & wrap_mask);
    end

endmodule

// File: rtl/wb_sram_target.sv
// ----------------------------------------------------------------------------
// wb_sram_target
// Wishbone B4 single-port SRAM responder with classic and registered-feedback
// incrementing bursts. Out-of-window accesses terminate with ERR.
//   clk  in  clock, all state on posedge
//   rstn in  synchronous active-low reset
//   s    wb_if.slave : ADR/DAT_W/SEL/CYC/STB/WE/CTI/BTE in, DAT_R/ACK/ERR out
// Optional build macro: WB_SRAM_TARGET_WAIT_EN inserts WAIT_CYCLES wait states
// before each classic termination and before the first beat of a burst.
// ----------------------------------------------------------------------------
module wb_sram_target
    import wb_pkg::*;
#(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = '0,
    parameter int                       DEPTH         = 1024,
    parameter int                       WAIT_CYCLES   = 2
) (
    input  logic clk,
    input  logic rstn,
    wb_if.slave  s
);

    localparam int BYTES     = WB_DATA_WIDTH / 8;
    localparam int OFF_BITS  = $clog2(BYTES);
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam logic [WB_ADDR_WIDTH:0] WINDOW = (WB_ADDR_WIDTH+1)'(DEPTH * BYTES);

    logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

    wb_sram_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0]     burst_addr_q, burst_addr_d;
    logic [ADDR_BITS-1:0]     next_addr, req_index, rd_index;
    logic                     ack_q, ack_d, err_q, err_d;
    logic                     overflow, rd_en;
    logic [WB_DATA_WIDTH-1:0] dat_q;
    logic [WB_ADDR_WIDTH-1:0] offset;
    logic                     in_range, req, incr, beat;

`ifdef WB_SRAM_TARGET_WAIT_EN
    localparam int WCW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           wait_burst_q, wait_burst_d;
    logic           wait_err_q, wait_err_d;
`else
    wire unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

    assign offset    = s.ADR - ADDR_BASE;
    assign in_range  = (s.ADR >= ADDR_BASE) && ({1'b0, offset} < WINDOW);
    assign req_index = offset[OFF_BITS +: ADDR_BITS];
    assign req       = s.CYC & s.STB;
    assign incr      = (s.CTI == WB_CTI_INCR);
    // A beat completes only while the master is strobing; a pending ACK is
    // held back during master wait cycles so the burst simply pauses.
    assign beat      = ack_q & req;

    assign s.ACK   = beat;
    assign s.ERR   = err_q & req;
    assign s.DAT_R = beat ? dat_q : '0;

    wb_burst_addr_gen #(
        .ADDR_BITS (ADDR_BITS)
    ) u_addr_gen (
        .addr      (burst_addr_q),
        .bte       (s.BTE),
        .next_addr (next_addr),
        .overflow  (overflow)
    );

    // Next-state logic. A dropped CYC abandons whatever is in flight. The
    // read port is loaded with the word that the next ACK will present, so
    // data for every burst beat is ready one cycle ahead.
    always_comb begin
        state_d      = state_q;
        burst_addr_d = burst_addr_q;
        ack_d        = ack_q;
        err_d        = err_q;
        rd_en        = 1'b0;
        rd_index     = burst_addr_q;
`ifdef WB_SRAM_TARGET_WAIT_EN
        wait_cnt_d   = wait_cnt_q;
        wait_burst_d = wait_burst_q;
        wait_err_d   = wait_err_q;
`endif
        if (!s.CYC) begin
            state_d = ST_IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s.STB) begin
                        burst_addr_d = req_index;
                        rd_index     = req_index;
`ifdef WB_SRAM_TARGET_WAIT_EN
                        state_d      = ST_WAIT;
                        wait_cnt_d   = WCW'(WAIT_CYCLES);
                        wait_burst_d = incr & in_range;
                        wait_err_d   = ~in_range;
`else
                        state_d      = (incr && in_range) ? ST_BURST : ST_CLASSIC;
                        ack_d        = in_range;
                        err_d        = ~in_range;
                        rd_en        = in_range;
`endif
                    end
                end
                ST_CLASSIC: begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
                ST_BURST: begin
                    if (err_q) begin
                        if (s.STB) begin
                            state_d = ST_IDLE;
                            err_d   = 1'b0;
                        end
                    end else if (beat) begin
                        burst_addr_d = next_addr;
                        if (!incr) begin
                            state_d = ST_IDLE;
                            ack_d   = 1'b0;
                        end else if (overflow) begin
                            ack_d = 1'b0;
                            err_d = 1'b1;
                        end else begin
                            rd_index = next_addr;
                            rd_en    = 1'b1;
                        end
                    end
                end
`ifdef WB_SRAM_TARGET_WAIT_EN
                ST_WAIT: begin
                    if (wait_cnt_q <= WCW'(1)) begin
                        state_d = wait_burst_q ? ST_BURST : ST_CLASSIC;
                        ack_d   = ~wait_err_q;
                        err_d   = wait_err_q;
                        rd_en   = ~wait_err_q;
                    end else begin
                        wait_cnt_d = wait_cnt_q - WCW'(1);
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    // Control registers and the registered read port. Memory contents are
    // deliberately left alone by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            burst_addr_q <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            dat_q        <= '0;
`ifdef WB_SRAM_TARGET_WAIT_EN
            wait_cnt_q   <= '0;
            wait_burst_q <= 1'b0;
            wait_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            burst_addr_q <= burst_addr_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            if (rd_en) begin
                dat_q <= mem[rd_index];
            end
`ifdef WB_SRAM_TARGET_WAIT_EN
            wait_cnt_q   <= wait_cnt_d;
            wait_burst_q <= wait_burst_d;
            wait_err_q   <= wait_err_d;
`endif
        end
    end

    // Byte-lane write port. Only an acknowledged, strobed beat writes, and a
    // beat caught by reset is discarded.
    always_ff @(posedge clk) begin
        if (rstn && beat && s.WE) begin
            for (int i = 0; i < BYTES; i++) begin
                if (s.SEL[i]) begin
                    mem[burst_addr_q][8*i +: 8] <= s.DAT_W[8*i +: 8];
                end
            end
        end
    end

endmodule
